// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the clear control and the RegFile write port.
// master = requester/control side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int RWIDTH = 5,
   parameter int NREGS  = 32
);
   logic              clr_req;
   logic              clr_busy;
   logic              a_valid;
   logic              a_ready;
   logic [RWIDTH-1:0] a_rd;
   logic [WIDTH-1:0]  a_data;
   logic              b_valid;
   logic              b_ready;
   logic [RWIDTH-1:0] b_rd;
   logic [WIDTH-1:0]  b_data;
   logic              rf_we;
   logic [RWIDTH-1:0] rf_rd;
   logic [WIDTH-1:0]  rf_indata;
   logic [NREGS-1:0]  pend_mask;

   modport master (
      output clr_req, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  clr_busy, a_ready, b_ready, rf_we, rf_rd, rf_indata, pend_mask
   );

   modport slave (
      input  clr_req, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output clr_busy, a_ready, b_ready, rf_we, rf_rd, rf_indata, pend_mask
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port owner of the RegFile: arbitrates two buffered writeback requesters
// and sweeps every register to zero after reset or on a clear request.
module regfile_wb_arbiter #(
   parameter int WIDTH  = 32,
   parameter int RWIDTH = 5,
   parameter int NREGS  = 32
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   typedef struct packed {
      logic              vld;
      logic [RWIDTH-1:0] rd;
      logic [WIDTH-1:0]  data;
   } wb_buf_t;

   state_e            state_q, state_d;
   logic [RWIDTH-1:0] cnt_q, cnt_d;
   logic              armed_q, armed_d;     // first cycle out of reset has passed
   logic              rr_q, rr_d;           // 1: B wins the next contested grant
   logic              older_b_q, older_b_d; // B entry arrived before the A entry
   wb_buf_t           buf_a_q, buf_a_d;
   wb_buf_t           buf_b_q, buf_b_d;

   logic run, contested, same_rd;
   logic grant_a, grant_b;
   logic load_a, load_b;
   logic a_stays, b_stays;

   assign run       = (state_q == ST_RUN);
   assign same_rd   = (buf_a_q.rd == buf_b_q.rd);
   assign contested = run & buf_a_q.vld & buf_b_q.vld & ~same_rd;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (run) begin
         if (buf_a_q.vld && buf_b_q.vld) begin
            grant_b = same_rd ? older_b_q : rr_q;
            grant_a = ~grant_b;
         end else begin
            grant_a = buf_a_q.vld;
            grant_b = buf_b_q.vld;
         end
      end
   end

   // Readies look only at state, clr_req and the buffers, never at the valids.
   assign bus.a_ready = run & ~bus.clr_req & (~buf_a_q.vld | grant_a);
   assign bus.b_ready = run & ~bus.clr_req & (~buf_b_q.vld | grant_b);

   // A transfer to r0 completes the handshake but is dropped here.
   assign load_a  = bus.a_valid & bus.a_ready & (bus.a_rd != '0);
   assign load_b  = bus.b_valid & bus.b_ready & (bus.b_rd != '0);
   assign a_stays = buf_a_q.vld & ~grant_a;
   assign b_stays = buf_b_q.vld & ~grant_b;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      armed_d   = 1'b1;
      rr_d      = rr_q;
      older_b_d = older_b_q;
      buf_a_d   = buf_a_q;
      buf_b_d   = buf_b_q;

      buf_a_d.vld = a_stays | load_a;
      if (load_a) begin
         buf_a_d.rd   = bus.a_rd;
         buf_a_d.data = bus.a_data;
      end
      buf_b_d.vld = b_stays | load_b;
      if (load_b) begin
         buf_b_d.rd   = bus.b_rd;
         buf_b_d.data = bus.b_data;
      end

      if (contested) begin
         rr_d = grant_a;
      end

      // Age only matters when both entries target the same register.
      if (load_a && load_b) begin
         older_b_d = 1'b0;
      end else if (load_a) begin
         older_b_d = b_stays;
      end else if (load_b) begin
         older_b_d = ~a_stays;
      end

      case (state_q)
         ST_CLEAR: begin
            if (armed_q) begin
               if (cnt_q == RWIDTH'(NREGS - 1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + RWIDTH'(1);
               end
            end
         end
         ST_RUN: begin
            if (bus.clr_req && !buf_a_q.vld && !buf_b_q.vld) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Write port is a pure function of registered state: no input reaches it.
   always_comb begin
      bus.rf_we     = 1'b0;
      bus.rf_rd     = '0;
      bus.rf_indata = '0;
      if (state_q == ST_CLEAR) begin
         bus.rf_we = armed_q;
         bus.rf_rd = cnt_q;
      end else if (grant_a) begin
         bus.rf_we     = 1'b1;
         bus.rf_rd     = buf_a_q.rd;
         bus.rf_indata = buf_a_q.data;
      end else if (grant_b) begin
         bus.rf_we     = 1'b1;
         bus.rf_rd     = buf_b_q.rd;
         bus.rf_indata = buf_b_q.data;
      end
   end

   assign bus.clr_busy  = (state_q == ST_CLEAR);
   assign bus.pend_mask = (buf_a_q.vld ? (NREGS'(1) << buf_a_q.rd) : '0)
                        | (buf_b_q.vld ? (NREGS'(1) << buf_b_q.rd) : '0);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         rr_q      <= 1'b0;
         older_b_q <= 1'b0;
         buf_a_q   <= '0;
         buf_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         rr_q      <= rr_d;
         older_b_q <= older_b_d;
         buf_a_q   <= buf_a_d;
         buf_b_q   <= buf_b_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write scoreboard, RegFile shadow, handshake checks.
module tb_regfile_wb_arbiter;

   localparam int WIDTH  = 32;
   localparam int RWIDTH = 5;
   localparam int NREGS  = 32;

   typedef struct {
      logic [RWIDTH-1:0] rd;
      logic [WIDTH-1:0]  data;
   } wr_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   wr_t  sb[$];
   wr_t  mon_e;
   logic [WIDTH-1:0] rf_model [NREGS];

   regfile_wb_arbiter_if #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .NREGS(NREGS)) bus ();

   regfile_wb_arbiter #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .NREGS(NREGS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [RWIDTH-1:0] rd, input logic [WIDTH-1:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic push_clear();
      for (int r = 0; r < NREGS; r++) push_wr(RWIDTH'(r), '0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clear_done(input string tag);
      int n;
      n = 0;
      while (bus.clr_busy !== 1'b0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      check(tag, bus.clr_busy, 1'b0);
   endtask

   function automatic logic all_regs_zero();
      logic ok;
      ok = 1'b1;
      for (int r = 0; r < NREGS; r++) if (rf_model[r] !== '0) ok = 1'b0;
      return ok;
   endfunction

   // Shadow RegFile written from the arbiter's write port.
   always @(posedge clk) begin
      if (bus.rf_we === 1'b1) rf_model[bus.rf_rd] <= bus.rf_indata;
   end

   // Every write the arbiter issues must match the next expected write in order.
   always @(negedge clk) begin
      if (bus.rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 64'(bus.rf_rd), 64'h1_0000);
         end else begin
            mon_e = sb.pop_front();
            check("write_rd", 64'(bus.rf_rd), 64'(mon_e.rd));
            check("write_data", 64'(bus.rf_indata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      int ia, ib, sa, sb_stall, max_a, max_b, n;
      tests = 0;
      fails = 0;
      for (int r = 0; r < NREGS; r++) rf_model[r] = 'x;
      reset       = 1'b1;
      bus.clr_req = 1'b0;
      bus.a_valid = 1'b0;
      bus.a_rd    = '0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_rd    = '0;
      bus.b_data  = '0;

      // 1: reset state, then the power-on clear sweep
      next_cycle();
      @(negedge clk);
      check("rst_rf_we", bus.rf_we, 1'b0);
      check("rst_a_ready", bus.a_ready, 1'b0);
      check("rst_b_ready", bus.b_ready, 1'b0);
      check("rst_clr_busy", bus.clr_busy, 1'b1);
      check("rst_pend_mask", bus.pend_mask, '0);
      next_cycle();
      reset = 1'b0;
      push_clear();
      wait_clear_done("clear1_done");
      check("clear1_drained", sb.size(), 0);
      check("clear1_regs_zero", all_regs_zero(), 1'b1);

      // 2: single write from A
      next_cycle();
      bus.a_valid = 1'b1;
      bus.a_rd    = 5'd5;
      bus.a_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t2_a_ready", bus.a_ready, 1'b1);
      push_wr(5'd5, 32'hDEAD_BEEF);
      next_cycle();
      bus.a_valid = 1'b0;
      @(negedge clk);
      check("t2_pend_set", bus.pend_mask, 32'h0000_0020);
      next_cycle();
      @(negedge clk);
      check("t2_pend_clr", bus.pend_mask, '0);
      check("t2_reg5", rf_model[5], 32'hDEAD_BEEF);

      // 3: both requesters streaming to different registers
      ia = 0; ib = 0; sa = 0; sb_stall = 0; max_a = 0; max_b = 0;
      next_cycle();
      for (int c = 0; c < 40 && (ia < 8 || ib < 8); c++) begin
         bus.a_valid = (ia < 8);
         bus.a_rd    = 5'd3;
         bus.a_data  = 32'(ia);
         bus.b_valid = (ib < 8);
         bus.b_rd    = 5'd4;
         bus.b_data  = 32'(100 + ib);
         @(negedge clk);
         if (bus.a_valid) begin
            if (bus.a_ready === 1'b1) begin
               push_wr(5'd3, 32'(ia));
               ia++;
               sa = 0;
            end else begin
               sa++;
               if (sa > max_a) max_a = sa;
            end
         end
         if (bus.b_valid) begin
            if (bus.b_ready === 1'b1) begin
               push_wr(5'd4, 32'(100 + ib));
               ib++;
               sb_stall = 0;
            end else begin
               sb_stall++;
               if (sb_stall > max_b) max_b = sb_stall;
            end
         end
         next_cycle();
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      check("t3_a_count", ia, 8);
      check("t3_b_count", ib, 8);
      check("t3_a_max_stall_le1", (max_a <= 1), 1'b1);
      check("t3_b_max_stall_le1", (max_b <= 1), 1'b1);
      repeat (4) next_cycle();
      check("t3_drained", sb.size(), 0);
      check("t3_reg3", rf_model[3], 32'd7);
      check("t3_reg4", rf_model[4], 32'd107);

      // 4: same-cycle writes to the same register, A first, B final
      bus.a_valid = 1'b1;
      bus.a_rd    = 5'd7;
      bus.a_data  = 32'd1;
      bus.b_valid = 1'b1;
      bus.b_rd    = 5'd7;
      bus.b_data  = 32'd2;
      @(negedge clk);
      check("t4_a_ready", bus.a_ready, 1'b1);
      check("t4_b_ready", bus.b_ready, 1'b1);
      push_wr(5'd7, 32'd1);
      push_wr(5'd7, 32'd2);
      next_cycle();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      @(negedge clk);
      check("t4_pend_c1", bus.pend_mask, 32'h0000_0080);
      next_cycle();
      @(negedge clk);
      check("t4_pend_c2", bus.pend_mask, 32'h0000_0080);
      next_cycle();
      @(negedge clk);
      check("t4_pend_c3", bus.pend_mask, '0);
      check("t4_reg7", rf_model[7], 32'd2);

      // 5: write to r0 is accepted and dropped
      next_cycle();
      bus.a_valid = 1'b1;
      bus.a_rd    = 5'd0;
      bus.a_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("t5_a_ready", bus.a_ready, 1'b1);
      next_cycle();
      bus.a_valid = 1'b0;
      @(negedge clk);
      check("t5_rf_we", bus.rf_we, 1'b0);
      check("t5_pend", bus.pend_mask, '0);
      next_cycle();
      @(negedge clk);
      check("t5_rf_we_late", bus.rf_we, 1'b0);

      // 6: clear request drains B, then reset lands mid-clear
      next_cycle();
      bus.b_valid = 1'b1;
      bus.b_rd    = 5'd9;
      bus.b_data  = 32'h55;
      @(negedge clk);
      check("t6_b_ready", bus.b_ready, 1'b1);
      push_wr(5'd9, 32'h55);
      next_cycle();
      bus.b_valid = 1'b0;
      bus.clr_req = 1'b1;
      @(negedge clk);
      check("t6_a_ready_clr", bus.a_ready, 1'b0);
      check("t6_b_ready_clr", bus.b_ready, 1'b0);
      check("t6_pend_b", bus.pend_mask, 32'h0000_0200);
      push_clear();
      n = 0;
      while (bus.clr_busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_clear_started", bus.clr_busy, 1'b1);
      next_cycle();
      bus.clr_req = 1'b0;
      n = 0;
      while (!(bus.rf_we === 1'b1 && bus.rf_rd === 5'd9) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t6_reached_idx9", bus.rf_rd, 5'd9);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      sb.delete();
      @(negedge clk);
      check("t6_rst_rf_we", bus.rf_we, 1'b0);
      check("t6_rst_clr_busy", bus.clr_busy, 1'b1);
      next_cycle();
      reset = 1'b0;
      push_clear();
      wait_clear_done("clear2_done");
      check("clear2_drained", sb.size(), 0);
      check("clear2_regs_zero", all_regs_zero(), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
